// File: rtl/decode_rf_stage.sv
// Decode stage with integrated register file, write-through bypass and stall-time operand refresh.
// Optional DECODE_ZERO_REG_EN: register 0 reads as zero and ignores writes.
module decode_rf_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int OFF_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic              wb_en,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        opcode,
  output logic [4:0]        dst,
  output logic [4:0]        src1_reg,
  output logic [4:0]        src2_reg,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic [OFF_W-1:0]  offsetlo
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
`ifdef DECODE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] rf_q [NREGS];

  logic              valid_q, valid_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [4:0]        dst_q, dst_d, src1_reg_q, src1_reg_d, src2_reg_q, src2_reg_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [OFF_W-1:0]  off_q, off_d;

  logic          capture, stall, wb_ok;
  logic [IW-1:0] wb_idx, rd1_idx, rd2_idx, held1_idx, held2_idx;
  logic [DATA_W-1:0] rd1_val, rd2_val;

  assign in_ready  = !valid_q || out_ready;
  assign capture   = in_valid && in_ready;
  assign stall     = valid_q && !out_ready;
  assign wb_idx    = wb_reg[IW-1:0];
  assign rd1_idx   = instruction[15 +: IW];
  assign rd2_idx   = instruction[10 +: IW];
  assign held1_idx = src1_reg_q[IW-1:0];
  assign held2_idx = src2_reg_q[IW-1:0];
  assign wb_ok     = wb_en && !(ZERO_REG && wb_idx == '0);

  // Operand reads see the write landing on the same edge, so capture never latches a stale value.
  always_comb begin
    rd1_val = (ZERO_REG && rd1_idx == '0) ? '0 : rf_q[rd1_idx];
    rd2_val = (ZERO_REG && rd2_idx == '0) ? '0 : rf_q[rd2_idx];
    if (wb_ok && wb_idx == rd1_idx) rd1_val = wb_data;
    if (wb_ok && wb_idx == rd2_idx) rd2_val = wb_data;
  end

  always_comb begin
    valid_d    = valid_q;
    opcode_d   = opcode_q;
    dst_d      = dst_q;
    src1_reg_d = src1_reg_q;
    src2_reg_d = src2_reg_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    off_d      = off_q;
    if (capture) begin
      valid_d    = 1'b1;
      opcode_d   = instruction[31:25];
      dst_d      = instruction[24:20];
      src1_reg_d = instruction[19:15];
      src2_reg_d = instruction[14:10];
      src1_d     = rd1_val;
      src2_d     = rd2_val;
      off_d      = instruction[OFF_W-1:0];
    end else if (stall) begin
      if (wb_ok && wb_idx == held1_idx) src1_d = wb_data;
      if (wb_ok && wb_idx == held2_idx) src2_d = wb_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= DATA_W'(i);
    end else if (wb_ok) begin
      rf_q[wb_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      dst_q      <= '0;
      src1_reg_q <= '0;
      src2_reg_q <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      off_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      dst_q      <= dst_d;
      src1_reg_q <= src1_reg_d;
      src2_reg_q <= src2_reg_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      off_q      <= off_d;
    end
  end

  assign out_valid = valid_q;
  assign opcode    = opcode_q;
  assign dst       = dst_q;
  assign src1_reg  = src1_reg_q;
  assign src2_reg  = src2_reg_q;
  assign src1      = src1_q;
  assign src2      = src2_q;
  assign offsetlo  = off_q;

endmodule

// File: doc/decode_rf_stage.md
Name: decode_rf_stage

Overview:
- Parametrised decode stage with an integrated architectural register file.
- Splits each 32-bit instruction into opcode, destination, source indices and low offset, and reads both source operands.
- Presents the results in a valid/ready-handshaked output register for the execute stage.
- Adds a writeback port with same-cycle write-through bypass and stall-time operand refresh.

Parameters:
- DATA_W, 32: width of each register and of the src1/src2 operands.
- NREGS, 32: number of registers. Must be a power of two, 2..32. Register indices use the low log2(NREGS) bits of each 5-bit field.
- OFF_W, 10: width of offsetlo, taken from instruction[OFF_W-1:0]. Range 1..10.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept an instruction this cycle.
- instruction  in  32  fields: [31:25] opcode, [24:20] dst, [19:15] src1, [14:10] src2, [OFF_W-1:0] offset.
- wb_en  in  1  register-file write enable.
- wb_reg  in  5  write index (low log2(NREGS) bits used).
- wb_data  in  DATA_W  write data.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- opcode  out  7  instruction[31:25].
- dst  out  5  instruction[24:20].
- src1_reg  out  5  instruction[19:15].
- src2_reg  out  5  instruction[14:10].
- src1  out  DATA_W  operand read from src1_reg.
- src2  out  DATA_W  operand read from src2_reg.
- offsetlo  out  OFF_W  instruction[OFF_W-1:0].

Behaviour:
- Reset (async, while rst=1):
  - out_valid=0; opcode, dst, src1_reg, src2_reg, src1, src2, offsetlo all 0.
  - reg[i]=i (zero-extended to DATA_W) for every i.
  - Reset mid-stall discards the held bundle.
- in_ready = !out_valid || out_ready. Combinational, no dependence on in_valid.
- Capture: when in_valid && in_ready at an edge, all output fields load from the instruction and out_valid<=1. Latency is 1 cycle from accepted instruction to out_valid.
- Drain: out_valid && out_ready && !in_valid at an edge gives out_valid<=0. Output fields hold their last values.
- Back-to-back: out_ready=1 with in_valid=1 every cycle sustains one instruction per cycle, no bubbles.
- Stall: out_valid && !out_ready. in_ready=0 and all output fields hold, except for operand refresh below.
- Register file:
  - Writes happen at the edge when wb_en=1: reg[wb_reg]<=wb_data.
  - Reads are indexed by the instruction fields during capture.
- Write-through bypass: on capture, if wb_en=1 and wb_reg matches a source index, that operand loads wb_data, not the old register value. src1 and src2 are checked independently; both may bypass.
- Stall refresh: while stalled, if wb_en=1 and wb_reg matches src1_reg/src2_reg, the matching operand is updated to wb_data at that edge. The held bundle never carries a value older than the register file.
- Index matching compares only the low log2(NREGS) bits.
- wb_en with no capture and no stall updates the register file only.

Optional Feature:
- Macro: DECODE_ZERO_REG_EN.
- Defined:
  - reg[0] reads as 0 at all times and writes to index 0 are ignored.
  - No bypass or refresh is applied for index 0.
  - reg[0] reset value is 0.
- Undefined: reg[0] is an ordinary register with reset value 0, writable and bypassable.

Test Plan:
- Reset, then in_valid=1 with instruction=0x0A3_10C00 (opcode 0x05, dst 3, src1 2, src2 3), out_ready=1 -> next cycle out_valid=1, src1=2, src2=3, src1_reg=2, src2_reg=3, dst=3.
- wb_en=1, wb_reg=7, wb_data=0xDEADBEEF in the same cycle as capturing an instruction with src1=7, src2=7 -> src1=src2=0xDEADBEEF. A later read of r7 returns 0xDEADBEEF.
- Capture with src2=5, then hold out_ready=0 for 3 cycles. In cycle 2 write r5=0x1234 -> src2 becomes 0x1234 while stalled. in_ready=0 throughout, other fields unchanged.
- Stream 4 instructions with in_valid=1, out_ready=1 -> 4 consecutive out_valid cycles, each bundle one cycle after its input. Then in_valid=0 -> out_valid=0 next cycle.
- Assert rst for one cycle while stalled with out_valid=1 -> out_valid=0 immediately (async), in_ready=1, r9 reads 9 afterwards.
- With DECODE_ZERO_REG_EN: write r0=0xFF, then decode with src1=0 -> src1=0. Without the macro -> src1=0xFF.
